// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared constants, state enums and SHA-256 helpers for the nonce searcher
// Contents: SHA256_IV, SHA256_K round constants, chunk padding constants,
//           header slice indices, top and lane FSM state enums, sigma helpers.
package miner_pkg;

   localparam logic [255:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   // Element 63 is listed first, so round r lives at index 63-r (see k_at).
   localparam logic [63:0][31:0] SHA256_K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   // Chunk 1 = {prefix(96), nonce(32), CHUNK1_PAD}: 640-bit message length.
   localparam logic [383:0] CHUNK1_PAD = {32'h80000000, 288'd0, 64'd640};
   // Chunk 2 = {first digest(256), CHUNK2_PAD}: 256-bit message length.
   localparam logic [255:0] CHUNK2_PAD = {32'h80000000, 160'd0, 64'd256};

   localparam int HDR_CHUNK0_MSB = 607;
   localparam int HDR_CHUNK0_LSB = 96;
   localparam int HDR_PREFIX_MSB = 95;
   localparam int HDR_PREFIX_LSB = 0;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK_RANGE, S_MID_START, S_MID_WAIT, S_SEARCH, S_DONE
   } top_state_t;

   typedef enum logic [2:0] {
      L_IDLE, L_H1_START, L_H1_WAIT, L_H2_START, L_H2_WAIT, L_CHECK, L_NEXT, L_SPENT
   } lane_state_t;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] k_at(input logic [5:0] r);
      return SHA256_K[6'd63 - r];
   endfunction

endpackage

// File: rtl/miner_lane.sv
// rtl/miner_lane.sv - one search lane: compressor, strided nonce counter, target compare
// Ports: go starts the lane at first_nonce, kill returns it to idle; hit/spent
//        report status, digest/nonce give the current result. borrow_start/
//        borrow_block/borrow_done lend the core for the midstate pass.
//        h2_done exists only with MINER_HASH_COUNT_EN.
module miner_lane
   import miner_pkg::*;
#(
   parameter int NUM_LANES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         go,
   input  logic         kill,
   input  logic [32:0]  first_nonce,
   input  logic [32:0]  nonce_end,
   input  logic [255:0] midstate,
   input  logic [95:0]  prefix,
   input  logic [255:0] target,
   input  logic         borrow_start,
   input  logic [511:0] borrow_block,
   output logic         borrow_done,
   output logic         hit,
   output logic         spent,
   output logic [255:0] digest,
   output logic [31:0]  nonce
`ifdef MINER_HASH_COUNT_EN
   ,
   output logic         h2_done
`endif
);

   localparam logic [32:0] STRIDE = 33'(NUM_LANES);

   lane_state_t  state_q, state_d;
   logic [32:0]  nonce_q, nonce_d;
   logic         borrow_q;
   logic         core_start, core_finish;
   logic [255:0] core_state_in, core_state_out;
   logic [511:0] core_block;

   sha256_compress u_core (
      .clk       (clk),
      .reset     (reset),
      .start     (core_start),
      .state_in  (core_state_in),
      .block     (core_block),
      .state_out (core_state_out),
      .finish    (core_finish)
   );

   always_comb begin
      state_d       = state_q;
      nonce_d       = nonce_q;
      core_start    = borrow_start;
      core_state_in = SHA256_IV;
      core_block    = borrow_block;
      case (state_q)
         L_IDLE: if (go) begin
            nonce_d = first_nonce;
            state_d = (first_nonce > nonce_end) ? L_SPENT : L_H1_START;
         end
         L_H1_START: begin
            core_start    = 1'b1;
            core_state_in = midstate;
            core_block    = {prefix, nonce_q[31:0], CHUNK1_PAD};
            state_d       = L_H1_WAIT;
         end
         L_H1_WAIT: if (core_finish) state_d = L_H2_START;
         L_H2_START: begin
            // state_out still holds the first hash until the next finish.
            core_start    = 1'b1;
            core_state_in = SHA256_IV;
            core_block    = {core_state_out, CHUNK2_PAD};
            state_d       = L_H2_WAIT;
         end
         L_H2_WAIT: if (core_finish) state_d = L_CHECK;
         L_CHECK:   state_d = L_NEXT;
         L_NEXT: begin
            nonce_d = nonce_q + STRIDE;
            state_d = (nonce_d > nonce_end) ? L_SPENT : L_H1_START;
         end
         L_SPENT:   state_d = L_SPENT;
         default:   state_d = L_IDLE;
      endcase
      if (kill) state_d = L_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= L_IDLE;
         nonce_q  <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         nonce_q <= nonce_d;
         // Tags the core's next finish as belonging to the borrower.
         if (borrow_start)                         borrow_q <= 1'b1;
         else if (core_start || core_finish || kill) borrow_q <= 1'b0;
      end
   end

   assign borrow_done = borrow_q && core_finish;
   assign hit         = (state_q == L_CHECK) && (core_state_out <= target);
   assign spent       = (state_q == L_SPENT);
   assign digest      = core_state_out;
   assign nonce       = nonce_q[31:0];
`ifdef MINER_HASH_COUNT_EN
   assign h2_done     = (state_q == L_H2_WAIT) && core_finish;
`endif

endmodule

// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - iterative SHA-256 compression, one round per clock
// Ports: clk, reset (async high); start loads state_in/block and (re)starts,
//        state_out holds the result, finish pulses one cycle when it updates.
module sha256_compress
   import miner_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [255:0] state_in,
   input  logic [511:0] block,
   output logic [255:0] state_out,
   output logic         finish
);

   logic [255:0]      init_q;
   logic [31:0]       a, b, c, d, e, f, g, h;
   logic [15:0][31:0] w_q;        // w_q[0] is the schedule word of the current round
   logic [5:0]        round_q;
   logic              running_q;
   logic [31:0]       t1, t2, w_new;

   always_comb begin
      t1    = h + bsig1(e) + ((e & f) ^ (~e & g)) + k_at(round_q) + w_q[0];
      t2    = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
      w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_q    <= '0;
         {a, b, c, d, e, f, g, h} <= '0;
         w_q       <= '0;
         round_q   <= '0;
         running_q <= 1'b0;
         state_out <= '0;
         finish    <= 1'b0;
      end else begin
         finish <= 1'b0;
         if (start) begin
            // A new start always wins; any job still in flight is dropped.
            init_q    <= state_in;
            {a, b, c, d, e, f, g, h} <= state_in;
            for (int i = 0; i < 16; i++) w_q[i] <= block[511 - 32*i -: 32];
            round_q   <= '0;
            running_q <= 1'b1;
         end else if (running_q) begin
            {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
            w_q[15] <= w_new;
            round_q <= round_q + 6'd1;
            if (round_q == 6'd63) begin
               running_q <= 1'b0;
               finish    <= 1'b1;
               state_out <= {init_q[255:224] + t1 + t2, init_q[223:192] + a,
                             init_q[191:160] + b,       init_q[159:128] + c,
                             init_q[127:96] + d + t1,   init_q[95:64] + e,
                             init_q[63:32] + f,         init_q[31:0] + g};
            end
         end
      end
   end

endmodule

// File: rtl/miner_multi_lane.sv
// rtl/miner_multi_lane.sv - parallel double-SHA256 nonce searcher over [nonce_start, nonce_end]
// Ports: clk, reset (async high), start, abort, blockHeader_noNonce, target,
//        nonce_start, nonce_end in; digest, golden_nonce, finish, found,
//        exhausted, busy out. MINER_HASH_COUNT_EN adds hash_count[63:0].
module miner_multi_lane
   import miner_pkg::*;
#(
   parameter int NUM_LANES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   input  logic [607:0] blockHeader_noNonce,
   input  logic [255:0] target,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_end,
   output logic [255:0] digest,
   output logic [31:0]  golden_nonce,
   output logic         finish,
   output logic         found,
   output logic         exhausted,
   output logic         busy
`ifdef MINER_HASH_COUNT_EN
   ,
   output logic [63:0]  hash_count
`endif
);

   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   top_state_t state_q, state_d;
   logic [607:0] hdr_q;
   logic [255:0] target_q, midstate_q;
   logic [31:0]  n_start_q, n_end_q;

   logic accept, go, kill, abort_now, borrow_start, set_found, set_exh, mid_done;
   logic [NUM_LANES-1:0] hit, spent, borrow_done;
   logic [255:0] lane_digest [NUM_LANES];
   logic [31:0]  lane_nonce  [NUM_LANES];
   logic [LANE_W-1:0] win_idx;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
`ifdef MINER_HASH_COUNT_EN
      logic h2_done;
`endif
      miner_lane #(.NUM_LANES(NUM_LANES)) u_lane (
         .clk          (clk),
         .reset        (reset),
         .go           (go),
         .kill         (kill),
         .first_nonce  ({1'b0, n_start_q} + 33'(l)),
         .nonce_end    ({1'b0, n_end_q}),
         .midstate     (midstate_q),
         .prefix       (hdr_q[HDR_PREFIX_MSB:HDR_PREFIX_LSB]),
         .target       (target_q),
         .borrow_start ((l == 0) ? borrow_start : 1'b0),
         .borrow_block (hdr_q[HDR_CHUNK0_MSB:HDR_CHUNK0_LSB]),
         .borrow_done  (borrow_done[l]),
         .hit          (hit[l]),
         .spent        (spent[l]),
         .digest       (lane_digest[l]),
         .nonce        (lane_nonce[l])
`ifdef MINER_HASH_COUNT_EN
         ,
         .h2_done      (h2_done)
`endif
      );
   end

   // Only lane 0 is ever lent out, so the OR is just its borrow_done.
   assign mid_done = |borrow_done;

   // Lowest-indexed hitting lane wins a same-cycle tie.
   always_comb begin
      win_idx = '0;
      for (int l = NUM_LANES - 1; l >= 0; l--) if (hit[l]) win_idx = LANE_W'(l);
   end

   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      go           = 1'b0;
      borrow_start = 1'b0;
      set_found    = 1'b0;
      set_exh      = 1'b0;
      abort_now    = abort && (state_q inside {S_CHECK_RANGE, S_MID_START, S_MID_WAIT, S_SEARCH});
      if (abort_now) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               accept  = 1'b1;
               state_d = S_CHECK_RANGE;
            end
            S_CHECK_RANGE: if (n_start_q > n_end_q) begin
               set_exh = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_MID_START;
            end
            S_MID_START: begin
               borrow_start = 1'b1;
               state_d      = S_MID_WAIT;
            end
            S_MID_WAIT: if (mid_done) begin
               go      = 1'b1;
               state_d = S_SEARCH;
            end
            S_SEARCH: if (|hit) begin
               set_found = 1'b1;
               state_d   = S_DONE;
            end else if (&spent) begin
               set_exh = 1'b1;
               state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
      kill = abort_now || set_found || (state_q == S_SEARCH && set_exh);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hdr_q        <= '0;
         target_q     <= '0;
         n_start_q    <= '0;
         n_end_q      <= '0;
         midstate_q   <= '0;
         digest       <= '0;
         golden_nonce <= '0;
         finish       <= 1'b0;
         found        <= 1'b0;
         exhausted    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         finish <= 1'b0;
         if (accept) begin
            hdr_q        <= blockHeader_noNonce;
            target_q     <= target;
            n_start_q    <= nonce_start;
            n_end_q      <= nonce_end;
            digest       <= '0;
            golden_nonce <= '0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            busy         <= 1'b1;
         end
         if (abort_now) busy <= 1'b0;
         if (go) midstate_q <= lane_digest[0];
         if (set_found) begin
            digest       <= lane_digest[win_idx];
            golden_nonce <= lane_nonce[win_idx];
            found        <= 1'b1;
            finish       <= 1'b1;
            busy         <= 1'b0;
         end
         if (set_exh) begin
            exhausted <= 1'b1;
            finish    <= 1'b1;
            busy      <= 1'b0;
         end
      end
   end

`ifdef MINER_HASH_COUNT_EN
   logic [4:0] n_h2;
   always_comb begin
      n_h2 = '0;
      for (int l = 0; l < NUM_LANES; l++) n_h2 = n_h2 + 5'(g_lane_h2(l));
   end

   function automatic logic g_lane_h2(input int idx);
      logic r;
      r = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) if (k == idx) r = h2_vec[k];
      return r;
   endfunction

   logic [NUM_LANES-1:0] h2_vec;
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_h2
      assign h2_vec[l] = g_lane[l].h2_done;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       hash_count <= '0;
      else if (accept) hash_count <= '0;
      else             hash_count <= hash_count + 64'(n_h2);
   end
`endif

endmodule

// File: tb/tb_miner_multi_lane.sv
// tb/tb_miner_multi_lane.sv - table-driven self-checking bench for miner_multi_lane
// Ports: none; drives the DUT with directed search vectors plus abort and reset sequences.
module tb_miner_multi_lane;

   logic         clk = 1'b0;
   logic         reset, start, abort;
   logic [607:0] hdr;
   logic [255:0] target;
   logic [31:0]  nonce_start, nonce_end;
   logic [255:0] digest;
   logic [31:0]  golden_nonce;
   logic         finish, found, exhausted, busy;
`ifdef MINER_HASH_COUNT_EN
   logic [63:0]  hash_count;
`endif

   int errors = 0;
   int checks = 0;
   int core_starts = 0;

   localparam logic [255:0] ONES = {256{1'b1}};
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   miner_multi_lane dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .abort               (abort),
      .blockHeader_noNonce (hdr),
      .target              (target),
      .nonce_start         (nonce_start),
      .nonce_end           (nonce_end),
      .digest              (digest),
      .golden_nonce        (golden_nonce),
      .finish              (finish),
      .found               (found),
      .exhausted           (exhausted),
      .busy                (busy)
`ifdef MINER_HASH_COUNT_EN
      ,
      .hash_count          (hash_count)
`endif
   );

   always #5 clk = ~clk;

   wire core_any = dut.g_lane[0].u_lane.core_start | dut.g_lane[1].u_lane.core_start |
                   dut.g_lane[2].u_lane.core_start | dut.g_lane[3].u_lane.core_start;
   always @(posedge clk) core_starts <= core_starts + (core_any ? 1 : 0);

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] ref_compress(input logic [255:0] st, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
                (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
      for (int i = 0; i < 64; i++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = st[255 - 32*i -: 32] + v[i];
      return r;
   endfunction

   function automatic logic [255:0] ref_dsha(input logic [607:0] h, input logic [31:0] n);
      logic [255:0] mid, h1;
      mid = ref_compress(IV, h[607:96]);
      h1  = ref_compress(mid, {h[95:0], n, 32'h80000000, 288'd0, 64'd640});
      return ref_compress(IV, {h1, 32'h80000000, 160'd0, 64'd256});
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      string        name;
      logic [255:0] tgt;
      logic [31:0]  ns, ne;
      bit           exp_found, exp_exh;
      logic [31:0]  exp_nonce;
      longint       exp_cnt;
      bit           no_core;
      int           max_cyc;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int cyc, extra, cs0;
      logic [255:0] exp_dig;
      exp_dig = v.exp_found ? ref_dsha(hdr, v.exp_nonce) : 256'd0;
      @(negedge clk);
      target = v.tgt; nonce_start = v.ns; nonce_end = v.ne; start = 1'b1;
      cs0 = core_starts;
      @(negedge clk);
      start = 1'b0;
      target = '0; nonce_start = 32'hdead; nonce_end = 32'hbeef;  // latched copies must be used
      chk({v.name, "_busy_run"}, busy, 1'b1);
      cyc = 1;
      while (!finish && cyc < v.max_cyc) begin
         @(negedge clk);
         cyc++;
      end
      chk({v.name, "_finish"}, finish, 1'b1);
      chk({v.name, "_found"}, found, v.exp_found);
      chk({v.name, "_exhausted"}, exhausted, v.exp_exh);
      chk({v.name, "_busy_end"}, busy, 1'b0);
      chk({v.name, "_nonce"}, golden_nonce, v.exp_found ? v.exp_nonce : 32'd0);
      chk({v.name, "_digest"}, digest, exp_dig);
`ifdef MINER_HASH_COUNT_EN
      chk({v.name, "_hash_count"}, hash_count, v.exp_cnt);
`endif
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (finish) extra++;
      end
      chk({v.name, "_single_pulse"}, extra, 0);
      if (v.no_core) chk({v.name, "_no_core_start"}, core_starts - cs0, 0);
   endtask

   task automatic start_long_search();
      @(negedge clk);
      target = '0; nonce_start = 32'd0; nonce_end = 32'hFFFFFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (150) @(negedge clk);
   endtask

   vec_t vecs [6];
   vec_t v7;

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      target = '0; nonce_start = '0; nonce_end = '0;
      for (int i = 0; i < 19; i++) hdr[i*32 +: 32] = (32'h9e3779b9 * (i + 1)) ^ 32'h5a5a1234;

      vecs[0] = '{"hit_lane0",   ONES,   32'h10,       32'hFF,       1'b1, 1'b0, 32'h10,       4, 1'b0, 2000};
      vecs[1] = '{"exh_0_7",     256'd0, 32'h0,        32'h7,        1'b0, 1'b1, 32'h0,        8, 1'b0, 2000};
      vecs[2] = '{"empty_range", ONES,   32'h5,        32'h4,        1'b0, 1'b1, 32'h0,        0, 1'b1, 3};
      vecs[3] = '{"top_edge",    256'd0, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        2, 1'b0, 2000};
      vecs[4] = '{"max_nonce",   ONES,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1, 1'b0, 2000};
      vecs[5] = '{"hit_3",       ONES,   32'h3,        32'd100,      1'b1, 1'b0, 32'h3,        4, 1'b0, 2000};
      v7      = '{"single_7",    ONES,   32'h7,        32'h7,        1'b1, 1'b0, 32'h7,        1, 1'b0, 2000};

      #22;
      chk("reset_busy", busy, 1'b0);
      chk("reset_found", found, 1'b0);
      chk("reset_exhausted", exhausted, 1'b0);
      chk("reset_finish", finish, 1'b0);
      chk("reset_digest", digest, 256'd0);
      chk("reset_nonce", golden_nonce, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Abort mid-search, then a fresh search must still work.
      start_long_search();
      chk("abort_busy_before", busy, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_found", found, 1'b0);
      chk("abort_exhausted", exhausted, 1'b0);
      begin
         int fin = 0;
         repeat (150) begin
            @(negedge clk);
            if (finish) fin++;
         end
         chk("abort_no_finish", fin, 0);
      end
      run_vec(v7);

      // Asynchronous reset mid-search clears outputs before the next edge.
      start_long_search();
      chk("areset_busy_before", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("areset_busy", busy, 1'b0);
      chk("areset_found", found, 1'b0);
      chk("areset_exhausted", exhausted, 1'b0);
      chk("areset_nonce", golden_nonce, 32'd0);
      chk("areset_digest", digest, 256'd0);
`ifdef MINER_HASH_COUNT_EN
      chk("areset_hash_count", hash_count, 64'd0);
`endif
      @(negedge clk);
      reset = 1'b0;
      run_vec(v7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
